// File: rtl/aes_key_sched_ctrl_if.sv
// ============================================================================
// Module      : aes_key_sched_ctrl_if
// Description : Bundle of the key-load handshake, expansion-engine link and
//               round-key read port of the AES-256 key schedule controller.
//               slave  - the controller side
//               master - the environment side (key source, engine, cipher)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_key_sched_ctrl_if #(
    parameter int unsigned RKW = 128
);
    // key load handshake
    logic [255:0]   key_in;
    logic           key_valid;
    logic           key_ready;
    logic           cipher_busy;
    // expansion engine link
    logic           ke_start;
    logic [255:0]   ke_key;
    logic           ke_rk_valid;
    logic [RKW-1:0] ke_rk;
    // round-key read port
    logic           rk_req;
    logic [3:0]     rk_idx;
    logic           rk_valid;
    logic [RKW-1:0] rk_data;
    logic           rk_miss;
    // status
    logic           keys_ready;
    logic           sched_done;
    logic           sched_err;

    modport slave (
        input  key_in, key_valid, cipher_busy, ke_rk_valid, ke_rk, rk_req, rk_idx,
        output key_ready, ke_start, ke_key, rk_valid, rk_data, rk_miss,
               keys_ready, sched_done, sched_err
    );

    modport master (
        output key_in, key_valid, cipher_busy, ke_rk_valid, ke_rk, rk_req, rk_idx,
        input  key_ready, ke_start, ke_key, rk_valid, rk_data, rk_miss,
               keys_ready, sched_done, sched_err
    );
endinterface

`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
// ============================================================================
// Module      : aes_key_sched_ctrl
// Description : Sequencing controller for the AES-256 key expansion engine.
//               Accepts a 256-bit key (valid/ready), pulses the engine start,
//               collects NUM_RK round keys into a local buffer and serves
//               indexed round-key reads with one cycle of latency. New keys
//               are held off while the cipher core is using the buffer.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous reset, active low
//               bus  - aes_key_sched_ctrl_if.slave (key load, engine link,
//                      read port and status)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_sched_ctrl #(
    parameter int unsigned NUM_RK  = 15,
    parameter int unsigned RKW     = 128,
    parameter int unsigned TIMEOUT = 64
) (
    input  wire logic           clk,
    input  wire logic           rst,
    aes_key_sched_ctrl_if.slave bus
);

    localparam int unsigned      c_tmr_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);
    localparam logic [3:0]       c_last_rk  = 4'(NUM_RK - 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_start   = 2'd1;
    localparam logic [1:0] c_st_collect = 2'd2;
    localparam logic [1:0] c_st_ready   = 2'd3;

    logic [1:0]         r_state;
    logic [255:0]       r_ke_key;
    logic [RKW-1:0]     r_buf [NUM_RK];
    logic [3:0]         r_rk_cnt;
    logic [c_tmr_w-1:0] r_timer;
    logic               r_keys_ready;
    logic               r_sched_done;
    logic               r_sched_err;
    logic               r_rk_valid;
    logic [RKW-1:0]     r_rk_data;
    logic               r_rk_miss;

    logic               w_accept;
    logic               w_rd_hit;

    // key_ready is also held low during reset so that every output of the
    // block reads 0 while rst is asserted.
    assign bus.key_ready = rst
                         && ((r_state == c_st_idle) || (r_state == c_st_ready))
                         && !bus.cipher_busy;
    assign w_accept      = bus.key_valid && bus.key_ready;
    assign bus.ke_start  = (r_state == c_st_start);

    // A read hits only against a complete schedule; an index beyond the
    // buffer (15 for AES-256) always misses and never touches r_buf.
    assign w_rd_hit = r_keys_ready && ({28'd0, bus.rk_idx} < NUM_RK);

    assign bus.ke_key     = r_ke_key;
    assign bus.keys_ready = r_keys_ready;
    assign bus.sched_done = r_sched_done;
    assign bus.sched_err  = r_sched_err;
    assign bus.rk_valid   = r_rk_valid;
    assign bus.rk_data    = r_rk_data;
    assign bus.rk_miss    = r_rk_miss;

    // ------------------------------------------------------------------
    // Schedule sequencing and round-key capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_ke_key     <= '0;
            r_rk_cnt     <= '0;
            r_timer      <= '0;
            r_keys_ready <= 1'b0;
            r_sched_done <= 1'b0;
            r_sched_err  <= 1'b0;
            for (int i = 0; i < int'(NUM_RK); i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_sched_done <= 1'b0;
            case (r_state)
                c_st_idle, c_st_ready: begin
                    // keys_ready falls on the accept edge, so a read issued
                    // in the accept cycle is still served from the old keys.
                    if (w_accept) begin
                        r_ke_key     <= bus.key_in;
                        r_keys_ready <= 1'b0;
                        r_sched_err  <= 1'b0;
                        r_state      <= c_st_start;
                    end
                end
                c_st_start: begin
                    r_rk_cnt <= '0;
                    r_timer  <= '0;
                    r_state  <= c_st_collect;
                end
                c_st_collect: begin
                    if (bus.ke_rk_valid) begin
                        r_buf[r_rk_cnt] <= bus.ke_rk;
                        r_rk_cnt        <= r_rk_cnt + 4'd1;
                        r_timer         <= '0;
                        if (r_rk_cnt == c_last_rk) begin
                            r_keys_ready <= 1'b1;
                            r_sched_done <= 1'b1;
                            r_state      <= c_st_ready;
                        end
                    end else if (r_timer == c_tmr_last) begin
                        // engine went quiet: abandon the schedule, leave the
                        // partially written buffer as-is (it is unreadable
                        // while keys_ready is 0)
                        r_sched_err <= 1'b1;
                        r_state     <= c_st_idle;
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-key read port, one cycle of latency
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rk_valid <= 1'b0;
            r_rk_data  <= '0;
            r_rk_miss  <= 1'b0;
        end else begin
            r_rk_valid <= bus.rk_req;
            r_rk_miss  <= bus.rk_req && !w_rd_hit;
            r_rk_data  <= (bus.rk_req && w_rd_hit) ? r_buf[bus.rk_idx] : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
// ============================================================================
// Module      : tb_aes_key_sched_ctrl
// Description : Directed self-checking bench for aes_key_sched_ctrl. Contains
//               an AES-256 key expansion model acting as the engine, which
//               returns one round key per cycle starting two cycles after
//               ke_start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_key_sched_ctrl;

    localparam logic [255:0] K1 = 256'h642423baa95efb4362d3f2ce993c0904150f258aa1fe796841d7b4429c9b5a30;
    localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K1_RK0  = 128'h642423baa95efb4362d3f2ce993c0904;
    localparam logic [127:0] K1_RK1  = 128'h150f258aa1fe796841d7b4429c9b5a30;
    localparam logic [127:0] K2_RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] K2_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   start_cnt = 0;
    int   eng_sent = 0;
    int   eng_limit = 15;
    logic [255:0] eng_key = '0;

    logic [2047:0] sbox_flat = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    aes_key_sched_ctrl_if #(.RKW(128)) bus ();

    aes_key_sched_ctrl #(
        .NUM_RK  (15),
        .RKW     (128),
        .TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ke_start === 1'b1) start_cnt++;
    end

    // ---------------- AES-256 key expansion model ----------------
    function automatic logic [31:0] sub_word(input logic [31:0] x);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[31-8*b -: 8] = sbox_flat[2047 - 8*int'(x[31-8*b -: 8]) -: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] k, input int rnd);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        rcon = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = rcon << 1;
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    endfunction

    // Engine: strobes eng_limit round keys, first one 2 cycles after ke_start
    initial begin : engine
        bus.ke_rk_valid = 1'b0;
        bus.ke_rk       = '0;
        forever begin
            @(negedge clk);
            if (bus.ke_start === 1'b1 && rst === 1'b1) begin
                eng_key  = bus.ke_key;
                eng_sent = 0;
                @(negedge clk);
                for (int i = 0; i < eng_limit; i++) begin
                    @(negedge clk);
                    if (rst !== 1'b1) break;
                    bus.ke_rk_valid = 1'b1;
                    bus.ke_rk       = round_key(eng_key, i);
                    eng_sent        = i + 1;
                end
                if (rst === 1'b1) @(negedge clk);
                bus.ke_rk_valid = 1'b0;
                bus.ke_rk       = '0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [390:0] all_outs();
        return {bus.key_ready, bus.ke_start, bus.ke_key, bus.rk_valid, bus.rk_data,
                bus.rk_miss, bus.keys_ready, bus.sched_done, bus.sched_err};
    endfunction

    task automatic load_key(input logic [255:0] k, output bit ok);
        ok = 1'b0;
        @(negedge clk); #1;
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.key_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int strobes);
        seen = 1'b0;
        strobes = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (bus.sched_done === 1'b1) begin seen = 1'b1; strobes = eng_sent; break; end
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic pre_v, output logic v,
                           output logic m, output logic [127:0] d);
        @(negedge clk); #1;
        pre_v      = bus.rk_valid;
        bus.rk_req = 1'b1;
        bus.rk_idx = idx;
        @(negedge clk); #1;
        v = bus.rk_valid; m = bus.rk_miss; d = bus.rk_data;
        bus.rk_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (all_outs() !== '0) begin
            failed++; $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bus.key_ready !== 1'b1 || bus.keys_ready !== 1'b0) begin
            failed++; $display("FAIL reset_release: key_ready=%b keys_ready=%b required 1/0",
                               bus.key_ready, bus.keys_ready);
        end
    endtask

    task automatic test_load_schedule();
        bit ok, seen; int n, s0;
        logic pv, v, m; logic [127:0] d;
        s0 = start_cnt;
        load_key(K1, ok);
        wait_done(seen, n);
        tests++;
        if (!ok || !seen || n != 15) begin
            failed++; $display("FAIL load_done: accepted=%0d done=%0d strobes=%0d required 1/1/15", ok, seen, n);
        end
        tests++;
        if (start_cnt - s0 != 1) begin
            failed++; $display("FAIL ke_start_pulses: got %0d required 1", start_cnt - s0);
        end
        tests++;
        if (bus.keys_ready !== 1'b1) begin
            failed++; $display("FAIL keys_ready_after_done: got %b required 1", bus.keys_ready);
        end
        read_rk(4'd0, pv, v, m, d);
        tests++;
        if (pv !== 1'b0 || v !== 1'b1 || m !== 1'b0 || d !== K1_RK0) begin
            failed++; $display("FAIL read_idx0: pre=%b valid=%b miss=%b data=%h required 0/1/0/%h", pv, v, m, d, K1_RK0);
        end
        read_rk(4'd1, pv, v, m, d);
        tests++;
        if (pv !== 1'b0 || v !== 1'b1 || m !== 1'b0 || d !== K1_RK1) begin
            failed++; $display("FAIL read_idx1: pre=%b valid=%b miss=%b data=%h required 0/1/0/%h", pv, v, m, d, K1_RK1);
        end
        // back-to-back reads of idx 2..14, one request per cycle
        @(negedge clk); #1;
        bus.rk_req = 1'b1;
        bus.rk_idx = 4'd2;
        for (int i = 2; i < 15; i++) begin
            @(negedge clk); #1;
            tests++;
            if (bus.rk_valid !== 1'b1 || bus.rk_miss !== 1'b0 || bus.rk_data !== round_key(K1, i)) begin
                failed++; $display("FAIL b2b_read_idx%0d: valid=%b miss=%b data=%h required 1/0/%h",
                                   i, bus.rk_valid, bus.rk_miss, bus.rk_data, round_key(K1, i));
            end
            if (i < 14) bus.rk_idx = 4'(i + 1);
            else        bus.rk_req = 1'b0;
        end
        @(negedge clk); #1;
        tests++;
        if (bus.rk_valid !== 1'b0 || bus.rk_miss !== 1'b0 || bus.rk_data !== '0) begin
            failed++; $display("FAIL read_idle: valid=%b miss=%b data=%h required all 0",
                               bus.rk_valid, bus.rk_miss, bus.rk_data);
        end
    endtask

    task automatic test_timeout();
        bit ok, found; logic pv, v, m; logic [127:0] d;
        eng_limit = 7;
        load_key(K2, ok);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (eng_sent == 7) begin found = 1'b1; break; end
        end
        repeat (64) @(negedge clk);
        #1;
        tests++;
        if (!ok || !found || bus.sched_err !== 1'b0) begin
            failed++; $display("FAIL timeout_early: accepted=%0d stalled=%0d sched_err=%b required 1/1/0", ok, found, bus.sched_err);
        end
        @(negedge clk); #1;
        tests++;
        if (bus.sched_err !== 1'b1 || bus.keys_ready !== 1'b0 || bus.key_ready !== 1'b1) begin
            failed++; $display("FAIL timeout_abort: sched_err=%b keys_ready=%b key_ready=%b required 1/0/1",
                               bus.sched_err, bus.keys_ready, bus.key_ready);
        end
        eng_limit = 15;
        read_rk(4'd3, pv, v, m, d);
        tests++;
        if (v !== 1'b1 || m !== 1'b1 || d !== '0) begin
            failed++; $display("FAIL timeout_read_miss: valid=%b miss=%b data=%h required 1/1/0", v, m, d);
        end
    endtask

    task automatic test_busy_hold();
        bit ok, seen; int n, s0;
        logic pv, v, m; logic [127:0] d;
        load_key(K1, ok);
        wait_done(seen, n);
        tests++;
        if (!seen || bus.sched_err !== 1'b0) begin
            failed++; $display("FAIL busy_setup: done=%0d sched_err=%b required 1/0", seen, bus.sched_err);
        end
        s0 = start_cnt;
        @(negedge clk); #1;
        bus.cipher_busy = 1'b1;
        bus.key_in      = K2;
        bus.key_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            tests++;
            if (bus.key_ready !== 1'b0 || bus.ke_start !== 1'b0) begin
                failed++; $display("FAIL busy_holdoff cycle %0d: key_ready=%b ke_start=%b required 0/0",
                                   i, bus.key_ready, bus.ke_start);
            end
        end
        tests++;
        if (start_cnt != s0 || bus.keys_ready !== 1'b1) begin
            failed++; $display("FAIL busy_no_start: starts=%0d keys_ready=%b required 0/1", start_cnt - s0, bus.keys_ready);
        end
        bus.cipher_busy = 1'b0;
        #1;
        tests++;
        if (bus.key_ready !== 1'b1) begin
            failed++; $display("FAIL busy_release_ready: key_ready=%b required 1", bus.key_ready);
        end
        @(negedge clk); #1;
        bus.key_valid = 1'b0;
        tests++;
        if (bus.keys_ready !== 1'b0 || bus.ke_start !== 1'b1) begin
            failed++; $display("FAIL busy_accept: keys_ready=%b ke_start=%b required 0/1", bus.keys_ready, bus.ke_start);
        end
        @(negedge clk); #1;
        tests++;
        if (bus.ke_start !== 1'b0) begin
            failed++; $display("FAIL busy_start_width: ke_start=%b required 0", bus.ke_start);
        end
        wait_done(seen, n);
        read_rk(4'd2, pv, v, m, d);
        tests++;
        if (!seen || v !== 1'b1 || m !== 1'b0 || d !== K2_RK2) begin
            failed++; $display("FAIL k2_idx2: done=%0d valid=%b miss=%b data=%h required 1/1/0/%h", seen, v, m, d, K2_RK2);
        end
        read_rk(4'd14, pv, v, m, d);
        tests++;
        if (v !== 1'b1 || m !== 1'b0 || d !== K2_RK14) begin
            failed++; $display("FAIL k2_idx14: valid=%b miss=%b data=%h required 1/0/%h", v, m, d, K2_RK14);
        end
    endtask

    task automatic test_same_cycle_read();
        bit seen; int n;
        @(negedge clk); #1;
        bus.key_in    = K1;
        bus.key_valid = 1'b1;
        bus.rk_req    = 1'b1;
        bus.rk_idx    = 4'd5;
        tests++;
        if (bus.key_ready !== 1'b1 || bus.keys_ready !== 1'b1) begin
            failed++; $display("FAIL same_cycle_setup: key_ready=%b keys_ready=%b required 1/1", bus.key_ready, bus.keys_ready);
        end
        @(negedge clk); #1;
        bus.key_valid = 1'b0;
        tests++;
        if (bus.rk_valid !== 1'b1 || bus.rk_miss !== 1'b0 || bus.rk_data !== round_key(K2, 5)) begin
            failed++; $display("FAIL same_cycle_old_key: valid=%b miss=%b data=%h required 1/0/%h",
                               bus.rk_valid, bus.rk_miss, bus.rk_data, round_key(K2, 5));
        end
        tests++;
        if (bus.keys_ready !== 1'b0) begin
            failed++; $display("FAIL same_cycle_keys_ready: got %b required 0", bus.keys_ready);
        end
        @(negedge clk); #1;
        bus.rk_req = 1'b0;
        tests++;
        if (bus.rk_valid !== 1'b1 || bus.rk_miss !== 1'b1 || bus.rk_data !== '0) begin
            failed++; $display("FAIL read_during_reload: valid=%b miss=%b data=%h required 1/1/0",
                               bus.rk_valid, bus.rk_miss, bus.rk_data);
        end
        wait_done(seen, n);
        tests++;
        if (!seen || n != 15) begin
            failed++; $display("FAIL same_cycle_reload_done: done=%0d strobes=%0d required 1/15", seen, n);
        end
    endtask

    task automatic test_idx15_miss();
        logic pv, v, m; logic [127:0] d;
        read_rk(4'd15, pv, v, m, d);
        tests++;
        if (v !== 1'b1 || m !== 1'b1 || d !== '0 || bus.keys_ready !== 1'b1) begin
            failed++; $display("FAIL idx15_miss: valid=%b miss=%b data=%h keys_ready=%b required 1/1/0/1",
                               v, m, d, bus.keys_ready);
        end
    endtask

    task automatic test_reset_mid_collect();
        bit ok, seen, found; int n;
        logic pv, v, m; logic [127:0] d;
        load_key(K2, ok);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (eng_sent == 9) begin found = 1'b1; break; end
        end
        #3;
        rst = 1'b0;
        #1;
        tests++;
        if (!found || all_outs() !== '0) begin
            failed++; $display("FAIL async_reset_outputs: reached9=%0d got %h required 0", found, all_outs());
        end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.key_ready !== 1'b1 || bus.keys_ready !== 1'b0 || bus.sched_err !== 1'b0) begin
            failed++; $display("FAIL reset_release_state: key_ready=%b keys_ready=%b sched_err=%b required 1/0/0",
                               bus.key_ready, bus.keys_ready, bus.sched_err);
        end
        read_rk(4'd0, pv, v, m, d);
        tests++;
        if (v !== 1'b1 || m !== 1'b1 || d !== '0) begin
            failed++; $display("FAIL post_reset_read: valid=%b miss=%b data=%h required 1/1/0", v, m, d);
        end
        load_key(K1, ok);
        wait_done(seen, n);
        tests++;
        if (!ok || !seen || n != 15 || bus.keys_ready !== 1'b1) begin
            failed++; $display("FAIL reload_done: accepted=%0d done=%0d strobes=%0d keys_ready=%b required 1/1/15/1",
                               ok, seen, n, bus.keys_ready);
        end
        @(negedge clk); #1;
        bus.rk_req = 1'b1;
        bus.rk_idx = 4'd0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #1;
            tests++;
            if (bus.rk_valid !== 1'b1 || bus.rk_miss !== 1'b0 || bus.rk_data !== round_key(K1, i)
                || (i == 0 && bus.rk_data !== K1_RK0) || (i == 1 && bus.rk_data !== K1_RK1)) begin
                failed++; $display("FAIL reload_read_idx%0d: valid=%b miss=%b data=%h required 1/0/%h",
                                   i, bus.rk_valid, bus.rk_miss, bus.rk_data, round_key(K1, i));
            end
            if (i < 14) bus.rk_idx = 4'(i + 1);
            else        bus.rk_req = 1'b0;
        end
    endtask

    initial begin : main
        bus.key_in      = '0;
        bus.key_valid   = 1'b0;
        bus.cipher_busy = 1'b0;
        bus.rk_req      = 1'b0;
        bus.rk_idx      = '0;
        test_reset();
        test_load_schedule();
        test_timeout();
        test_busy_hold();
        test_same_cycle_read();
        test_idx15_miss();
        test_reset_mid_collect();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
